// File: rtl/usb_rx_pkg.sv
// Shared types and helpers for the USB full-speed receive controller.
package usb_rx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SYNC,
    CMP_SYNC,
    CHK_PID,
    DATA,
    WRITE,
    BYTE_EOP,
    DONE_WAIT,
    ERR,
    ERR_WAIT1,
    ERR_WAIT2
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_SYNC = 3'd1,
    ERR_PID  = 3'd2,
    ERR_EOP  = 3'd3,
    ERR_OVF  = 3'd4
  } err_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'h80;

  // A PID byte carries its own check nibble: upper half is the complement of the lower.
  function automatic logic pid_ok(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

endpackage

// File: rtl/rx_byte_counter.sv
// Saturating per-packet byte counter: clears on packet start, never wraps past max.
module rx_byte_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] max,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count < max)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// Receiver control FSM: SYNC/PID checking, byte writes to the RX FIFO, EOP and error recovery.
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter int                 DATA_W       = 8,
  parameter logic [DATA_W-1:0]  SYNC_PATTERN = DATA_W'(SYNC_DEFAULT),
  parameter int                 MAX_BYTES    = 64,
  parameter int                 CHECK_PID    = 1,
  parameter int                 CNT_W        = 7
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              d_edge,
  input  logic              eop,
  input  logic              shift_enable,
  input  logic [DATA_W-1:0] rcv_data,
  input  logic              byte_received,
  output logic              rcving,
  output logic              w_enable,
  output logic              r_error,
  output logic [2:0]        err_code,
  output logic [CNT_W-1:0]  byte_count,
  output logic              pkt_done
);

  state_t state_q, state_d;
  err_t   err_q, err_d;
  logic   eop_bit;
  logic   sync_entry;
  logic   at_max;

  assign eop_bit    = eop && shift_enable;
  assign sync_entry = (state_d == SYNC) && (state_q != SYNC);
  assign at_max     = (byte_count >= CNT_W'(MAX_BYTES));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (d_edge) begin
        state_d = SYNC;
        err_d   = ERR_NONE;
      end
      SYNC: if (byte_received) state_d = CMP_SYNC;
      CMP_SYNC: begin
        if (rcv_data == SYNC_PATTERN) begin
          state_d = CHK_PID;
        end else begin
          state_d = ERR;
          err_d   = ERR_SYNC;
        end
      end
      CHK_PID: begin
        if (byte_received) begin
          if ((CHECK_PID == 0) || pid_ok(rcv_data[7:0])) begin
            state_d = WRITE;
          end else begin
            state_d = ERR;
            err_d   = ERR_PID;
          end
        end else if (eop_bit) begin
          state_d = ERR_WAIT1;
          err_d   = ERR_EOP;
        end
      end
      // A completed byte takes priority over an EOP sampled in the same cycle.
      DATA: begin
        if (byte_received) begin
          if (!at_max) begin
            state_d = WRITE;
          end else begin
            state_d = ERR;
            err_d   = ERR_OVF;
          end
        end else if (eop_bit) begin
          state_d = ERR_WAIT1;
          err_d   = ERR_EOP;
        end
      end
      WRITE:     state_d = BYTE_EOP;
      BYTE_EOP:  if (shift_enable) state_d = eop ? DONE_WAIT : DATA;
      DONE_WAIT: if (d_edge) state_d = IDLE;
      ERR:       if (eop_bit) state_d = ERR_WAIT1;
      ERR_WAIT1: if (d_edge) state_d = ERR_WAIT2;
      ERR_WAIT2: if (d_edge) begin
        state_d = SYNC;
        err_d   = ERR_NONE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    rcving   = state_q inside {SYNC, CMP_SYNC, CHK_PID, DATA, WRITE, BYTE_EOP, ERR};
    w_enable = (state_q == WRITE);
    pkt_done = (state_q == BYTE_EOP) && shift_enable && eop;
  end

  assign err_code = err_q;
  assign r_error  = (err_q != ERR_NONE);

  rx_byte_counter #(
    .CNT_W(CNT_W)
  ) u_byte_counter (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (sync_entry),
    .inc   (state_q == WRITE),
    .max   (CNT_W'(MAX_BYTES)),
    .count (byte_count)
  );

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Scoreboard bench for usb_rx_ctrl: three instances cover default, CHECK_PID=0 and MAX_BYTES=4.
`timescale 1ns/1ps
module tb_usb_rx_ctrl;
  import usb_rx_pkg::*;

  localparam int CNT_W = 7;

  typedef enum int {EV_W, EV_D} ev_kind_t;
  typedef struct {
    int       inst;
    ev_kind_t kind;
    int       cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_edge = 1'b0, eop = 1'b0, shift_enable = 1'b0, byte_received = 1'b0;
  logic [7:0] rcv_data = '0;
  int         sel = 0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  ev_t        sb[$];

  logic [2:0]       de, eo, se, br, rcv_v, wen_v, rerr_v, done_v;
  logic [2:0]       ec_v [3];
  logic [CNT_W-1:0] bc_v [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_gate
    assign de[g] = d_edge && (sel == g);
    assign eo[g] = eop && (sel == g);
    assign se[g] = shift_enable && (sel == g);
    assign br[g] = byte_received && (sel == g);
  end

  usb_rx_ctrl u_dut0 (
    .clk(clk), .n_rst(n_rst), .d_edge(de[0]), .eop(eo[0]), .shift_enable(se[0]),
    .rcv_data(rcv_data), .byte_received(br[0]), .rcving(rcv_v[0]), .w_enable(wen_v[0]),
    .r_error(rerr_v[0]), .err_code(ec_v[0]), .byte_count(bc_v[0]), .pkt_done(done_v[0])
  );

  usb_rx_ctrl #(.CHECK_PID(0)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .d_edge(de[1]), .eop(eo[1]), .shift_enable(se[1]),
    .rcv_data(rcv_data), .byte_received(br[1]), .rcving(rcv_v[1]), .w_enable(wen_v[1]),
    .r_error(rerr_v[1]), .err_code(ec_v[1]), .byte_count(bc_v[1]), .pkt_done(done_v[1])
  );

  usb_rx_ctrl #(.MAX_BYTES(4)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .d_edge(de[2]), .eop(eo[2]), .shift_enable(se[2]),
    .rcv_data(rcv_data), .byte_received(br[2]), .rcving(rcv_v[2]), .w_enable(wen_v[2]),
    .r_error(rerr_v[2]), .err_code(ec_v[2]), .byte_count(bc_v[2]), .pkt_done(done_v[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int inst, input ev_kind_t kind);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: inst %0d kind %0d at cyc %0d, none expected",
               inst, kind, cyc);
    end else begin
      e = sb.pop_front();
      check("event_inst", inst, e.inst);
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: every write strobe or packet-done pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wen_v[i] === 1'b1) sb_pop(i, EV_W);
      if (done_v[i] === 1'b1) sb_pop(i, EV_D);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_pulse();
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
  endtask

  task automatic sbit(input logic e, input bit exp_done);
    shift_enable = 1'b1;
    eop = e;
    if (exp_done) sb.push_back('{sel, EV_D, cyc});
    tick();
    shift_enable = 1'b0;
    eop = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input bit exp_w);
    sbit(1'b0, 1'b0);
    sbit(1'b0, 1'b0);
    rcv_data = b;
    byte_received = 1'b1;
    if (exp_w) sb.push_back('{sel, EV_W, cyc + 1});
    tick();
    byte_received = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    for (int i = 0; i < 3; i++) begin
      check("reset_rcving", rcv_v[i], 0);
      check("reset_w_enable", wen_v[i], 0);
      check("reset_r_error", rerr_v[i], 0);
      check("reset_err_code", ec_v[i], 0);
      check("reset_byte_count", bc_v[i], 0);
      check("reset_pkt_done", done_v[i], 0);
    end
    tick();
    n_rst = 1'b1;
    tick();

    // 1: good packet
    sel = 0;
    edge_pulse();
    check("t1_rcving_sync", rcv_v[0], 1);
    rx_byte(8'h80, 1'b0);
    rx_byte(8'hA5, 1'b1);
    rx_byte(8'h12, 1'b1);
    rx_byte(8'h34, 1'b1);
    sbit(1'b0, 1'b0);
    sbit(1'b1, 1'b1);
    check("t1_byte_count", bc_v[0], 3);
    check("t1_r_error", rerr_v[0], 0);
    check("t1_err_code", ec_v[0], 0);
    check("t1_rcving_done", rcv_v[0], 0);
    edge_pulse();

    // 2: bad SYNC, error held through EOP and two edges, cleared on SYNC re-entry
    edge_pulse();
    check("t2_count_cleared", bc_v[0], 0);
    rx_byte(8'h81, 1'b0);
    tick();
    check("t2_err_code", ec_v[0], 1);
    check("t2_r_error", rerr_v[0], 1);
    check("t2_rcving_err", rcv_v[0], 1);
    rx_byte(8'h12, 1'b0);
    sbit(1'b1, 1'b0);
    check("t2_rcving_wait1", rcv_v[0], 0);
    check("t2_r_error_wait1", rerr_v[0], 1);
    check("t2_err_code_wait1", ec_v[0], 1);
    edge_pulse();
    check("t2_r_error_wait2", rerr_v[0], 1);
    edge_pulse();
    check("t2_r_error_cleared", rerr_v[0], 0);
    check("t2_err_code_cleared", ec_v[0], 0);
    check("t2_rcving_resync", rcv_v[0], 1);
    rx_byte(8'h80, 1'b0);
    rx_byte(8'hA5, 1'b1);
    sbit(1'b0, 1'b0);
    sbit(1'b1, 1'b1);
    check("t2_byte_count", bc_v[0], 1);
    check("t2_r_error_end", rerr_v[0], 0);
    edge_pulse();

    // 3a: bad PID with checking enabled
    do_reset();
    edge_pulse();
    rx_byte(8'h80, 1'b0);
    rx_byte(8'hA6, 1'b0);
    check("t3a_err_code", ec_v[0], 2);
    check("t3a_r_error", rerr_v[0], 1);
    check("t3a_byte_count", bc_v[0], 0);

    // 3b: same PID with checking disabled is written
    sel = 1;
    do_reset();
    edge_pulse();
    rx_byte(8'h80, 1'b0);
    rx_byte(8'hA6, 1'b1);
    sbit(1'b0, 1'b0);
    sbit(1'b1, 1'b1);
    check("t3b_byte_count", bc_v[1], 1);
    check("t3b_err_code", ec_v[1], 0);
    check("t3b_r_error", rerr_v[1], 0);
    edge_pulse();

    // 4: EOP three bits into the second data byte
    sel = 0;
    do_reset();
    edge_pulse();
    rx_byte(8'h80, 1'b0);
    rx_byte(8'hA5, 1'b1);
    rx_byte(8'h12, 1'b1);
    sbit(1'b0, 1'b0);
    sbit(1'b0, 1'b0);
    sbit(1'b0, 1'b0);
    sbit(1'b0, 1'b0);
    sbit(1'b1, 1'b0);
    check("t4_err_code", ec_v[0], 3);
    check("t4_byte_count", bc_v[0], 2);
    check("t4_rcving", rcv_v[0], 0);
    check("t4_r_error", rerr_v[0], 1);

    // 5: overflow with MAX_BYTES=4
    sel = 2;
    do_reset();
    edge_pulse();
    rx_byte(8'h80, 1'b0);
    rx_byte(8'hA5, 1'b1);
    rx_byte(8'h11, 1'b1);
    rx_byte(8'h22, 1'b1);
    rx_byte(8'h33, 1'b1);
    rx_byte(8'h44, 1'b0);
    check("t5_err_code", ec_v[2], 4);
    check("t5_r_error", rerr_v[2], 1);
    check("t5_byte_count", bc_v[2], 4);
    check("t5_rcving_err", rcv_v[2], 1);
    rx_byte(8'h55, 1'b0);
    sbit(1'b1, 1'b0);
    check("t5_rcving_wait", rcv_v[2], 0);
    check("t5_byte_count_end", bc_v[2], 4);

    // 6: reset asserted during WRITE, then a clean packet
    sel = 0;
    do_reset();
    edge_pulse();
    rx_byte(8'h80, 1'b0);
    sbit(1'b0, 1'b0);
    sbit(1'b0, 1'b0);
    rcv_data = 8'hA5;
    byte_received = 1'b1;
    tick();
    byte_received = 1'b0;
    check("t6_w_enable_before", wen_v[0], 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("t6_w_enable", wen_v[0], 0);
    check("t6_rcving", rcv_v[0], 0);
    check("t6_r_error", rerr_v[0], 0);
    check("t6_err_code", ec_v[0], 0);
    check("t6_byte_count", bc_v[0], 0);
    check("t6_pkt_done", done_v[0], 0);
    check("t6_state", u_dut0.state_q, IDLE);
    tick();
    n_rst = 1'b1;
    tick();
    edge_pulse();
    rx_byte(8'h80, 1'b0);
    rx_byte(8'hA5, 1'b1);
    rx_byte(8'h12, 1'b1);
    sbit(1'b0, 1'b0);
    sbit(1'b1, 1'b1);
    check("t6_byte_count_after", bc_v[0], 2);
    check("t6_r_error_after", rerr_v[0], 0);
    edge_pulse();

    tick();
    tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
